// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// ------------
// EX/MEM pipeline boundary of the 16-bit core.
//
// Responsibilities:
//   - Registers the execute-stage result and the memory/writeback control
//     bits for the memory stage.
//   - Owns the architectural {Z, V, N} flag register that branch resolution
//     reads.
//   - Owns the halt latch. Once HLT is captured, the stage only produces
//     bubbles until reset.
//
// Ports:
//   clk, rst           core clock; synchronous active-high reset
//   stall              hold every register, the flags and the state
//   flush              load a bubble instead of the incoming instruction
//   in_valid           execute stage presents a real instruction
//   in_opcode          4-bit opcode
//   in_result          execute-unit result (RED arrives sign-extended)
//   in_ovfl            signed overflow from the ADD/SUB adder
//   in_store_data      forwarded rt value for SW
//   in_dst             destination register index
//   in_reg_write, in_mem_read, in_mem_write   control bits
//   out_*              registered copies of the above; control bits are 0
//                      for bubbles
//   out_halt           HLT currently occupies this stage
//   flags              {Z, V, N} architectural flags
//   halted             sticky: a HLT has been captured

module ex_mem_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_ovfl,
    input  logic [WIDTH-1:0] in_store_data,
    input  logic [3:0]       in_dst,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    output logic             out_valid,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [3:0]       out_dst,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_halt,
    output logic [2:0]       flags,
    output logic             halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t state;
    logic   flag_z;
    logic   flag_v;
    logic   flag_n;
    logic   capture;

    // A real instruction is taken only while running and not being flushed.
    // Every other non-stalled edge loads a bubble.
    assign capture = in_valid && !flush && (state == ST_RUN);

    // Single register block for the pipeline latch, flags and halt FSM.
    // On a bubble, the data fields (result, store data, destination) keep
    // their old values. Only the validity and side-effect bits are cleared,
    // so that downstream logic cannot act on the stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_result     <= '0;
            out_store_data <= '0;
            out_dst        <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_halt       <= 1'b0;
            flag_z         <= 1'b0;
            flag_v         <= 1'b0;
            flag_n         <= 1'b0;
        end else if (!stall) begin
            if (capture) begin
                out_valid      <= 1'b1;
                out_opcode     <= in_opcode;
                out_result     <= in_result;
                out_store_data <= in_store_data;
                out_dst        <= in_dst;
                out_reg_write  <= in_reg_write;
                out_mem_read   <= in_mem_read;
                out_mem_write  <= in_mem_write;
                out_halt       <= (in_opcode == OP_HLT);
                if (in_opcode == OP_HLT) begin
                    state <= ST_HALTED;
                end
                // Only the adder produces meaningful V and N. The logic and
                // shift ops refresh Z alone. Everything else leaves the flags
                // alone.
                case (in_opcode)
                    OP_ADD, OP_SUB: begin
                        flag_z <= (in_result == '0);
                        flag_v <= in_ovfl;
                        flag_n <= in_result[WIDTH-1];
                    end
                    OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                        flag_z <= (in_result == '0);
                    end
                    default: begin
                    end
                endcase
            end else begin
                out_valid     <= 1'b0;
                out_opcode    <= '0;
                out_reg_write <= 1'b0;
                out_mem_read  <= 1'b0;
                out_mem_write <= 1'b0;
                out_halt      <= 1'b0;
            end
        end
    end

    assign flags  = {flag_z, flag_v, flag_n};
    assign halted = (state == ST_HALTED);

endmodule
